// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: scans a register range through a regfile read port and streams each word as bytes.
// Define REGDUMP_HDR_EN to prefix every word with a header byte {3'b101, index}.
module regfile_dump_reader #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] FirstReg,
   input  logic [ADDR_W-1:0] LastReg,
   output logic [ADDR_W-1:0] rA,
   input  logic [DATA_W-1:0] R1,
   output logic [7:0]        TxData,
   output logic              TxValid,
   input  logic              TxReady,
   output logic              Busy,
   output logic              Done
);
   localparam int NB = DATA_W / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] SEND = 3'd3;
   localparam logic [2:0] DONE = 3'd4;
`ifdef REGDUMP_HDR_EN
   localparam logic [2:0] HDR  = 3'd2;
`endif
   logic [2:0]        state;
   logic [ADDR_W-1:0] index;
   logic [ADDR_W-1:0] last;
   logic [DATA_W-1:0] word;
   logic [CW-1:0]     cnt;
   logic [7:0]        data_byte;
   logic              last_byte;
   assign data_byte = MSB_FIRST ? word[DATA_W-1 -: 8] : word[7:0];
   assign last_byte = cnt == CW'(NB - 1);
`ifdef REGDUMP_HDR_EN
   assign TxData  = (state == SEND) ? data_byte : (state == HDR) ? {3'b101, index[4:0]} : 8'h00;
   assign TxValid = (state == SEND) || (state == HDR);
   assign Busy    = (state == LOAD) || (state == HDR) || (state == SEND);
`else
   assign TxData  = (state == SEND) ? data_byte : 8'h00;
   assign TxValid = state == SEND;
   assign Busy    = (state == LOAD) || (state == SEND);
`endif
   assign Done = state == DONE;
   // rA only moves on entry to LOAD, so it holds steady everywhere else
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         index <= '0;
         last  <= '0;
         rA    <= '0;
         word  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (Start) begin
               index <= FirstReg;
               last  <= LastReg;
               rA    <= FirstReg;
               state <= LOAD;
            end
            LOAD: begin
               word  <= R1;
               cnt   <= '0;
`ifdef REGDUMP_HDR_EN
               state <= HDR;
`else
               state <= SEND;
`endif
            end
`ifdef REGDUMP_HDR_EN
            HDR: if (TxReady) state <= SEND;
`endif
            SEND: if (TxReady) begin
               if (!last_byte) begin
                  cnt  <= cnt + 1'b1;
                  word <= MSB_FIRST ? word << 8 : word >> 8;
               end else if (index == last) begin
                  state <= DONE;
               end else begin
                  index <= index + 1'b1;
                  rA    <= index + 1'b1;
                  state <= LOAD;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
